average_mem_rd_responder: RTL and testbench
===========================================

Name: average_mem_rd_responder

Overview:
- Memory-side read responder for the average accelerator: consumes the 97-bit AXI4 read-address packet stream (ar_channel) and returns 519-bit read-data beats (r_channel).
- Converts each burst into single-beat 512-bit reads on a local SRAM-style port; a credit-limited FIFO absorbs r-channel backpressure.
- Sits directly downstream of average's memory_channels_ar_channel_rsc_* outputs and upstream of its memory_channels_r_channel_rsc_* inputs.

Parameters:
- FIFO_DEPTH, 8, read-data buffer entries (power of 2, >=2); also the outstanding-read credit limit.
- MEM_AW, 58, memory word-address width (512-bit words).

Ports:
- clk  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- ar_dat  input  97  {region[3:0],qos[3:0],cache[3:0],prot[2:0],lock,burst[1:0],size[2:0],len[7:0],addr[63:0],id[3:0]} MSB..LSB.
- ar_vld  input  1  ar packet valid.
- ar_rdy  output  1  ar packet accepted when ar_vld&ar_rdy.
- r_dat  output  519  {id[3:0],data[511:0],resp[1:0],last} MSB..LSB.
- r_vld  output  1  r beat valid.
- r_rdy  input  1  r beat consumed when r_vld&r_rdy.
- mem_req  output  1  read request.
- mem_addr  output  MEM_AW  word address = byte addr[63:6].
- mem_gnt  input  1  request accepted this cycle.
- mem_rvalid  input  1  read data return, in request order, latency >=1.
- mem_rdata  input  512  read data.

Behaviour:
- Reset (rst high at clk edge): state IDLE, ar_rdy=0, r_vld=0, mem_req=0, mem_addr=0, FIFO empty, credits=FIFO_DEPTH, beat counters 0. Reset mid-burst abandons the burst; mem_rvalid arriving later than 1 cycle after reset deassertion is a protocol violation (no handling required).
- FSM: IDLE -> (ar_vld) capture packet, ar_rdy pulses 1 for exactly that cycle -> ISSUE if legal, ERR otherwise.
- Legal = size==6 and burst in {FIXED(00), INCR(01)}. Otherwise ERR.
- ISSUE: mem_req=1 while beats_issued<=len and credits>0; mem_addr = base word + beats_issued (INCR, MEM_AW-bit wrap-around, no 4KB check) or base word (FIXED). Base word = addr[63:6] (low 6 bits ignored). Each mem_req&mem_gnt: beats_issued++, credits--. After last grant -> DRAIN.
- Credits: credits-- on grant, ++ on r handshake; same-cycle grant and pop net 0. Guarantees no FIFO overflow; mem_rvalid writes FIFO unconditionally.
- FIFO entry: {data, last}; last set for beat index len. r_dat = {captured id, fifo data, resp=2'b00, fifo last}.
- ERR: no memory access; emits len+1 beats directly: data=0, resp=2'b10 (SLVERR), last on beat len, id captured. Then IDLE.
- DRAIN: wait for handshake of last beat -> IDLE. ar_rdy=0 outside IDLE; one burst in flight at a time.
- r_vld = FIFO non-empty (ISSUE/DRAIN) or ERR-beat pending; r_dat stable while r_vld&!r_rdy.
- Latency: ar handshake cycle N -> first mem_req cycle N+1; mem_rvalid cycle M -> r_vld cycle M+1 (registered FIFO output).
- len=0: single beat, last=1. len=255: 256 beats, counters 9 bits.
- mem_req may be deasserted without grant only when credits hit 0.

Decomposition:
- Shared package avg_axi_pkg: ar/r field offsets and widths, BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, BEAT_SIZE_LOG2=6, packet pack/unpack functions.
- One sub-module: avg_rd_fifo (synchronous FIFO, parameterised width/depth, push/pop/full/empty/count).

Test Plan:
- INCR addr=0x1000 len=3 size=6 id=5, memory returns word index: mem_addr 0x40,0x41,0x42,0x43; four r beats id=5 resp=00, last only on 4th, data matches.
- FIXED addr=0x2040 len=2: mem_addr 0x81 three times; three beats, last on third.
- r_rdy held 0 for 40 cycles during INCR len=15, FIFO_DEPTH=8: exactly 8 grants then mem_req=0; no data loss; all 16 beats in order after r_rdy=1.
- WRAP burst (burst=10) len=1 id=3, then size=5 INCR len=0: zero mem_req; beats {3,0,10,0},{3,0,10,1}, then one beat resp=10 last=1.
- Back-to-back ar_vld held high with two packets: second accepted only cycle after first burst's last handshake; ar_rdy single-cycle pulses.
- rst asserted mid-INCR len=7 after 3 beats: next cycle r_vld=0, mem_req=0, ar_rdy=0; new len=0 burst completes correctly.

Source files
------------

// File: rtl/avg_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avg_axi_pkg
// Brief    : AXI4 read-channel packet layout, codes and helpers for average.
// Revision : 1.0 - initial release
// ============================================================================
package avg_axi_pkg;

    localparam int ID_W           = 4;
    localparam int LEN_W          = 8;
    localparam int ADDR_W         = 64;
    localparam int DATA_W         = 512;
    localparam int AR_W           = 97;
    localparam int R_W            = 519;
    localparam int CNT_W          = LEN_W + 1;
    localparam int BEAT_SIZE_LOG2 = 6;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    // Field order is MSB..LSB of the 97-bit ar packet.
    typedef struct packed {
        logic [3:0]        region;
        logic [3:0]        qos;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic              lock;
        logic [1:0]        burst;
        logic [2:0]        size;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
    } ar_pkt_t;

    function automatic ar_pkt_t ar_unpack(input logic [AR_W-1:0] dat);
        return ar_pkt_t'(dat);
    endfunction

    function automatic logic [R_W-1:0] r_pack(input logic [ID_W-1:0]   id,
                                              input logic [DATA_W-1:0] data,
                                              input logic [1:0]        resp,
                                              input logic              last);
        return {id, data, resp, last};
    endfunction

    // Only full-width beats with FIXED or INCR addressing are served.
    function automatic logic ar_legal(input ar_pkt_t pkt);
        logic burst_ok;
        case (pkt.burst)
            BURST_FIXED, BURST_INCR: burst_ok = 1'b1;
            BURST_WRAP:              burst_ok = 1'b0;
            default:                 burst_ok = 1'b0;
        endcase
        return burst_ok && (pkt.size == 3'(BEAT_SIZE_LOG2));
    endfunction

endpackage
`default_nettype wire

// File: rtl/avg_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : avg_rd_fifo
// Brief    : Synchronous FIFO, power-of-two depth, head visible combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module avg_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (c_aw + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_aw'(1);
            if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
            if (w_push && !w_pop)      r_count <= r_count + (c_aw + 1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (c_aw + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/average_mem_rd_responder.sv
`default_nettype none
// ============================================================================
// Module   : average_mem_rd_responder
// Brief    : Turns AXI4 read bursts into single-beat SRAM reads, credit-limited.
// Revision : 1.0 - initial release
// ============================================================================
module average_mem_rd_responder
    import avg_axi_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int MEM_AW     = 58
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AR_W-1:0]   ar_dat,
    input  logic              ar_vld,
    output logic              ar_rdy,
    output logic [R_W-1:0]    r_dat,
    output logic              r_vld,
    input  logic              r_rdy,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int c_cred_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_ent_w  = DATA_W + 1;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ID_W-1:0]     r_id;
    logic [LEN_W-1:0]    r_len;
    logic [MEM_AW-1:0]   r_base;
    logic                r_fixed;
    logic [CNT_W-1:0]    r_issued;
    logic [CNT_W-1:0]    r_rcvd;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [c_cred_w-1:0] r_credits;
    ar_pkt_t             w_ar;
    logic                w_busy;
    logic                w_grant;
    logic                w_push;
    logic                w_pop;
    logic                w_err_hs;
    logic                w_issue_last;
    logic                w_err_last;
    logic                w_fifo_vld;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_ent_w-1:0]  w_fifo_rdata;
    logic [c_cred_w-1:0] w_fifo_count;
    logic                w_unused_ok;

    assign w_ar         = ar_unpack(ar_dat);
    assign ar_rdy       = (r_state == ST_IDLE) && ar_vld;
    assign w_busy       = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign w_issue_last = (r_issued == {1'b0, r_len});
    assign w_err_last   = (r_err_cnt == {1'b0, r_len});

    // Credits cap reads in flight plus buffered beats at the FIFO depth.
    assign mem_req  = (r_state == ST_ISSUE) && (r_issued <= {1'b0, r_len}) && (r_credits != '0);
    assign mem_addr = mem_req ? (r_fixed ? r_base : r_base + MEM_AW'(r_issued)) : '0;
    assign w_grant  = mem_req && mem_gnt;

    // Stale returns after an abandoned burst never reach the buffer.
    assign w_push     = mem_rvalid && w_busy;
    assign w_fifo_vld = w_busy && !w_fifo_empty;
    assign w_pop      = w_fifo_vld && r_rdy;
    assign w_err_hs   = (r_state == ST_ERR) && r_rdy;

    assign r_vld = w_fifo_vld || (r_state == ST_ERR);
    assign r_dat = (r_state == ST_ERR)
                 ? r_pack(r_id, {DATA_W{1'b0}}, RESP_SLVERR, w_err_last)
                 : r_pack(r_id, w_fifo_rdata[c_ent_w-1:1], RESP_OKAY, w_fifo_rdata[0]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (ar_vld) w_state_nxt = ar_legal(w_ar) ? ST_ISSUE : ST_ERR;
            ST_ISSUE: if (w_grant && w_issue_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_pop && w_fifo_rdata[0]) w_state_nxt = ST_IDLE;
            ST_ERR:   if (w_err_hs && w_err_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_id      <= '0;
            r_len     <= '0;
            r_base    <= '0;
            r_fixed   <= 1'b0;
            r_issued  <= '0;
            r_rcvd    <= '0;
            r_err_cnt <= '0;
            r_credits <= c_cred_w'(FIFO_DEPTH);
        end else begin
            r_state <= w_state_nxt;
            if (ar_rdy) begin
                r_id      <= w_ar.id;
                r_len     <= w_ar.len;
                r_base    <= MEM_AW'(w_ar.addr >> BEAT_SIZE_LOG2);
                r_fixed   <= (w_ar.burst == BURST_FIXED);
                r_issued  <= '0;
                r_rcvd    <= '0;
                r_err_cnt <= '0;
            end else begin
                if (w_grant)  r_issued  <= r_issued + CNT_W'(1);
                if (w_push)   r_rcvd    <= r_rcvd + CNT_W'(1);
                if (w_err_hs) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (w_grant && !w_pop)      r_credits <= r_credits - c_cred_w'(1);
            else if (w_pop && !w_grant) r_credits <= r_credits + c_cred_w'(1);
        end
    end

    avg_rd_fifo #(
        .WIDTH (c_ent_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({mem_rdata, (r_rcvd == {1'b0, r_len})}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_unused_ok = ^{w_ar.region, w_ar.qos, w_ar.cache, w_ar.prot, w_ar.lock,
                           w_fifo_full, w_fifo_count};

endmodule
`default_nettype wire

// File: tb/tb_average_mem_rd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_average_mem_rd_responder
// Brief    : Scoreboard bench for average_mem_rd_responder with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_average_mem_rd_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [96:0]  ar_dat;
    logic         ar_vld;
    logic         ar_rdy;
    logic [518:0] r_dat;
    logic         r_vld;
    logic         r_rdy;
    logic         mem_req;
    logic [57:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [511:0] mem_rdata;

    logic [518:0] exp_r[$];
    logic [57:0]  exp_addr[$];
    logic [511:0] ret_q[$];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   grant_cnt = 0;
    int   beats_seen = 0;
    int   last_hs_cyc = 0;
    bit   gnt_alt = 1'b0;
    logic prev_ar_rdy = 1'b0;

    average_mem_rd_responder #(
        .FIFO_DEPTH (8),
        .MEM_AW     (58)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ar_dat     (ar_dat),
        .ar_vld     (ar_vld),
        .ar_rdy     (ar_rdy),
        .r_dat      (r_dat),
        .r_vld      (r_vld),
        .r_rdy      (r_rdy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [518:0] act, input logic [518:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Memory model: returns the word address as data, one cycle after grant.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            ret_q.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end else if (ret_q.size() != 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ret_q.pop_front();
        end else begin
            mem_rvalid = 1'b0;
        end
        mem_gnt = gnt_alt ? cyc[0] : 1'b1;
    end

    // Monitor: grants, r beats and ar_rdy pulse width, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (ar_rdy) begin
                n_checks++;
                if (prev_ar_rdy) begin
                    n_fail++;
                    $display("FAIL ar_rdy_pulse: high on consecutive cycles at %0d, expected single-cycle pulse", cyc);
                end
            end
            prev_ar_rdy = ar_rdy;
            if (mem_req && mem_gnt) begin
                grant_cnt++;
                ret_q.push_back(512'(mem_addr));
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_req_unexpected: got request addr %h, expected no request", mem_addr);
                end else begin
                    chk("mem_addr", 519'(mem_addr), 519'(exp_addr.pop_front()));
                end
            end
            if (r_vld && r_rdy) begin
                beats_seen++;
                if (r_dat[0]) last_hs_cyc = cyc;
                if (exp_r.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL r_beat_unexpected: got %h, expected no beat", r_dat);
                end else begin
                    chk("r_dat", r_dat, exp_r.pop_front());
                end
            end
        end else begin
            prev_ar_rdy = 1'b0;
        end
    end

    task automatic expect_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
        logic [57:0] base;
        logic [57:0] w;
        logic        legal;
        base  = addr[63:6];
        legal = (size == 3'd6) && (burst == 2'b00 || burst == 2'b01);
        for (int i = 0; i <= int'(len); i++) begin
            if (legal) begin
                w = (burst == 2'b01) ? base + 58'(i) : base;
                exp_addr.push_back(w);
                exp_r.push_back({id, 512'(w), 2'b00, (i == int'(len))});
            end else begin
                exp_r.push_back({id, 512'd0, 2'b10, (i == int'(len))});
            end
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit keep,
                           output int acc_cyc);
        int k;
        ar_dat = {4'h0, 4'h0, 4'h0, 3'h0, 1'b0, burst, size, len, addr, id};
        ar_vld = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ar_rdy && k < 2000);
        acc_cyc = cyc;
        chk("ar_accept", 519'(ar_rdy), 519'(1));
        @(posedge clk);
        #1;
        if (!keep) ar_vld = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int k;
        k = 0;
        while ((exp_r.size() != 0 || exp_addr.size() != 0) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("drain_r_left", 519'(exp_r.size()), 519'(0));
        chk("drain_addr_left", 519'(exp_addr.size()), 519'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1;
        int acc2;
        int start;
        int k;
        rst    = 1'b1;
        ar_vld = 1'b0;
        ar_dat = '0;
        r_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ar_rdy", 519'(ar_rdy), 519'(0));
        chk("rst_r_vld", 519'(r_vld), 519'(0));
        chk("rst_mem_req", 519'(mem_req), 519'(0));
        chk("rst_mem_addr", 519'(mem_addr), 519'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // INCR 0x1000 len=3: words 0x40..0x43
        expect_burst(4'd5, 64'h1000, 8'd3, 3'd6, 2'b01);
        send_ar(4'd5, 64'h1000, 8'd3, 3'd6, 2'b01, 1'b0, acc1);
        wait_drain(200);

        // FIXED 0x2040 len=2 with a stalling grant: word 0x81 three times
        gnt_alt = 1'b1;
        expect_burst(4'd9, 64'h2040, 8'd2, 3'd6, 2'b00);
        send_ar(4'd9, 64'h2040, 8'd2, 3'd6, 2'b00, 1'b0, acc1);
        wait_drain(200);
        gnt_alt = 1'b0;

        // Backpressure: credits stop issue after FIFO_DEPTH grants
        r_rdy = 1'b0;
        grant_cnt = 0;
        expect_burst(4'd1, 64'h3000, 8'd15, 3'd6, 2'b01);
        send_ar(4'd1, 64'h3000, 8'd15, 3'd6, 2'b01, 1'b0, acc1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("bp_grants", 519'(grant_cnt), 519'(8));
        chk("bp_mem_req", 519'(mem_req), 519'(0));
        chk("bp_r_vld", 519'(r_vld), 519'(1));
        @(posedge clk);
        #1;
        r_rdy = 1'b1;
        wait_drain(500);

        // Illegal bursts: WRAP then size=5
        expect_burst(4'd3, 64'h0, 8'd1, 3'd6, 2'b10);
        send_ar(4'd3, 64'h0, 8'd1, 3'd6, 2'b10, 1'b0, acc1);
        expect_burst(4'd7, 64'h40, 8'd0, 3'd5, 2'b01);
        send_ar(4'd7, 64'h40, 8'd0, 3'd5, 2'b01, 1'b0, acc1);
        wait_drain(200);

        // Back-to-back with ar_vld held high
        expect_burst(4'd4, 64'h5000, 8'd1, 3'd6, 2'b01);
        expect_burst(4'd6, 64'h6000, 8'd0, 3'd6, 2'b00);
        send_ar(4'd4, 64'h5000, 8'd1, 3'd6, 2'b01, 1'b1, acc1);
        send_ar(4'd6, 64'h6000, 8'd0, 3'd6, 2'b00, 1'b0, acc2);
        chk("b2b_accept_cycle", 519'(acc2), 519'(last_hs_cyc + 1));
        wait_drain(200);

        // Reset in the middle of INCR len=7
        start = beats_seen;
        expect_burst(4'd2, 64'h8000, 8'd7, 3'd6, 2'b01);
        send_ar(4'd2, 64'h8000, 8'd7, 3'd6, 2'b01, 1'b0, acc1);
        k = 0;
        while (beats_seen < start + 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_beats", 519'(beats_seen >= start + 3), 519'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_r.delete();
        exp_addr.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_r_vld", 519'(r_vld), 519'(0));
        chk("post_rst_mem_req", 519'(mem_req), 519'(0));
        chk("post_rst_ar_rdy", 519'(ar_rdy), 519'(0));
        @(posedge clk);
        #1;
        expect_burst(4'd8, 64'h9000, 8'd0, 3'd6, 2'b01);
        send_ar(4'd8, 64'h9000, 8'd0, 3'd6, 2'b01, 1'b0, acc1);
        wait_drain(200);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
